// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared widths, operation encoding and request record for the
//               multiply/divide functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int unsigned c_XLEN          = 64;
    localparam int unsigned c_TRANS_ID_BITS = 3;

    typedef enum logic [3:0] {
        MUL    = 4'd0,
        MULH   = 4'd1,
        MULHSU = 4'd2,
        MULHU  = 4'd3,
        MULW   = 4'd4,
        DIV    = 4'd5,
        DIVU   = 4'd6,
        REM    = 4'd7,
        REMU   = 4'd8,
        DIVW   = 4'd9,
        DIVUW  = 4'd10,
        REMW   = 4'd11,
        REMUW  = 4'd12
    } fu_op_t;

    typedef struct packed {
        fu_op_t                     operator;
        logic [c_XLEN-1:0]          operand_a;
        logic [c_XLEN-1:0]          operand_b;
        logic [c_TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    function automatic logic is_mul_op(input fu_op_t op);
        return op inside {MUL, MULH, MULHSU, MULHU, MULW};
    endfunction

    function automatic logic is_div_op(input fu_op_t op);
        return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic div_is_signed(input fu_op_t op);
        return op inside {DIV, REM, DIVW, REMW};
    endfunction

    function automatic logic div_is_word(input fu_op_t op);
        return op inside {DIVW, DIVUW, REMW, REMUW};
    endfunction

    function automatic logic div_is_rem(input fu_op_t op);
        return op inside {REM, REMU, REMW, REMUW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_serdiv.sv
`default_nettype none
// ============================================================================
// Module      : serdiv
// Description : Serial radix-2 restoring divider, one quotient bit per cycle,
//               with a fixed-latency sign/special-case correction stage.
// Revision    : 1.0 - initial release
// ============================================================================
module serdiv
    import mult_pkg::*;
#(
    parameter int unsigned XLEN    = c_XLEN,
    parameter int unsigned ID_BITS = c_TRANS_ID_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  fu_op_t             operator,
    input  logic [XLEN-1:0]    operand_a,
    input  logic [XLEN-1:0]    operand_b,
    input  logic [ID_BITS-1:0] in_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic [ID_BITS-1:0] out_id
);

    localparam int unsigned c_CNT_W = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIX    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_div;
    logic [XLEN-1:0]    r_dividend;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic               r_is_rem;
    logic               r_is_w;
    logic [ID_BITS-1:0] r_id;
    logic [XLEN-1:0]    r_result;
    logic               r_out_valid;

    logic               w_start;
    logic               w_sgn;
    logic               w_word;
    logic [XLEN-1:0]    w_a_ext;
    logic [XLEN-1:0]    w_b_ext;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_abs;
    logic [XLEN-1:0]    w_b_abs;
    logic [XLEN:0]      w_shift;
    logic [XLEN+1:0]    w_diff;
    logic               w_q_bit;
    logic [XLEN-1:0]    w_rem_next;
    logic [XLEN-1:0]    w_q_fin;
    logic [XLEN-1:0]    w_r_fin;
    logic [XLEN-1:0]    w_sel;
    logic [XLEN-1:0]    w_final;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_start   = in_valid && in_ready && !flush;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign out_id    = r_id;

    assign w_sgn  = div_is_signed(operator);
    assign w_word = div_is_word(operator);

    // Word ops divide the sign/zero-extended low halves at full width, so the
    // same iteration count serves both forms and latency never changes.
    if (XLEN > 32) begin : g_word64
        assign w_a_ext = w_word ? {{(XLEN-32){w_sgn & operand_a[31]}}, operand_a[31:0]} : operand_a;
        assign w_b_ext = w_word ? {{(XLEN-32){w_sgn & operand_b[31]}}, operand_b[31:0]} : operand_b;
        assign w_final = r_is_w ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;
    end else begin : g_word32
        assign w_a_ext = operand_a;
        assign w_b_ext = operand_b;
        assign w_final = w_sel;
    end

    assign w_a_neg = w_sgn & w_a_ext[XLEN-1];
    assign w_b_neg = w_sgn & w_b_ext[XLEN-1];
    assign w_a_abs = w_a_neg ? -w_a_ext : w_a_ext;
    assign w_b_abs = w_b_neg ? -w_b_ext : w_b_ext;

    assign w_shift    = {r_rem, r_quo[XLEN-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_div};
    assign w_q_bit    = ~w_diff[XLEN+1];
    assign w_rem_next = w_q_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

    // Most-negative / -1 falls out of the magnitude path unchanged; only a
    // zero divisor needs an explicit override.
    always_comb begin
        w_q_fin = r_neg_q ? -r_quo : r_quo;
        w_r_fin = r_neg_r ? -r_rem : r_rem;
        if (r_div_zero) begin
            w_q_fin = '1;
            w_r_fin = r_dividend;
        end
        w_sel = r_is_rem ? w_r_fin : w_q_fin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_dividend  <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_is_rem    <= 1'b0;
            r_is_w      <= 1'b0;
            r_id        <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_DIVIDE: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result    <= w_final;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_start) begin
                r_state    <= S_DIVIDE;
                r_cnt      <= '0;
                r_rem      <= '0;
                r_quo      <= w_a_abs;
                r_div      <= w_b_abs;
                r_dividend <= w_a_ext;
                r_neg_q    <= w_a_neg ^ w_b_neg;
                r_neg_r    <= w_a_neg;
                r_div_zero <= (w_b_ext == '0);
                r_is_rem   <= div_is_rem(operator);
                r_is_w     <= w_word;
                r_id       <= in_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
// Module      : mult
// Description : Multiply/divide functional unit: single-cycle pipelined
//               multiplier plus serial divider sharing one result port.
// Revision    : 1.0 - initial release
// ============================================================================
module mult
    import mult_pkg::*;
#(
    parameter int unsigned XLEN          = c_XLEN,
    parameter int unsigned TRANS_ID_BITS = c_TRANS_ID_BITS
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fu_data_t                 fu_data_i,
    input  logic                     mult_valid_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     mult_valid_o,
    output logic                     mult_ready_o,
    output logic [TRANS_ID_BITS-1:0] mult_trans_id_o
);

    logic                     w_accept;
    logic                     w_is_mul;
    logic                     w_is_div;
    logic                     w_a_sx;
    logic                     w_b_sx;
    logic [2*XLEN-1:0]        w_a_ext;
    logic [2*XLEN-1:0]        w_b_ext;
    logic [2*XLEN-1:0]        w_prod;
    logic [XLEN-1:0]          w_mulw_res;
    logic [XLEN-1:0]          w_mul_res;

    logic                     r_mul_valid;
    logic [XLEN-1:0]          r_mul_result;
    logic [TRANS_ID_BITS-1:0] r_mul_id;

    logic                     w_div_in_ready;
    logic                     w_div_valid;
    logic [XLEN-1:0]          w_div_result;
    logic [TRANS_ID_BITS-1:0] w_div_id;

    assign w_is_mul = is_mul_op(fu_data_i.operator);
    assign w_is_div = is_div_op(fu_data_i.operator);
    assign w_accept = mult_valid_i && mult_ready_o && !flush_i;

    // Extending both operands to the full product width makes one unsigned
    // multiplier produce correct high halves for every signedness mix.
    assign w_a_sx  = (fu_data_i.operator == MULH) || (fu_data_i.operator == MULHSU);
    assign w_b_sx  = (fu_data_i.operator == MULH);
    assign w_a_ext = {{XLEN{w_a_sx & fu_data_i.operand_a[XLEN-1]}}, fu_data_i.operand_a};
    assign w_b_ext = {{XLEN{w_b_sx & fu_data_i.operand_b[XLEN-1]}}, fu_data_i.operand_b};
    assign w_prod  = w_a_ext * w_b_ext;

    if (XLEN > 32) begin : g_mulw
        assign w_mulw_res = {{(XLEN-32){w_prod[31]}}, w_prod[31:0]};
    end else begin : g_no_mulw
        assign w_mulw_res = w_prod[XLEN-1:0];
    end

    always_comb begin
        w_mul_res = w_prod[XLEN-1:0];
        case (fu_data_i.operator)
            MULH, MULHSU, MULHU: w_mul_res = w_prod[2*XLEN-1:XLEN];
            MULW:                w_mul_res = w_mulw_res;
            default:             w_mul_res = w_prod[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mul_valid  <= 1'b0;
            r_mul_result <= '0;
            r_mul_id     <= '0;
        end else begin
            r_mul_valid <= w_accept && w_is_mul;
            if (w_accept && w_is_mul) begin
                r_mul_result <= w_mul_res;
                r_mul_id     <= fu_data_i.trans_id;
            end
        end
    end

    serdiv #(
        .XLEN    (XLEN),
        .ID_BITS (TRANS_ID_BITS)
    ) u_serdiv (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (flush_i),
        .in_valid  (w_accept && w_is_div),
        .in_ready  (w_div_in_ready),
        .operator  (fu_data_i.operator),
        .operand_a (fu_data_i.operand_a),
        .operand_b (fu_data_i.operand_b),
        .in_id     (fu_data_i.trans_id),
        .out_valid (w_div_valid),
        .out_ready (!r_mul_valid),
        .result    (w_div_result),
        .out_id    (w_div_id)
    );

    assign mult_ready_o = w_div_in_ready;

    // Multiplier has priority; a colliding divider result stays parked in
    // serdiv until the port is free.
    always_comb begin
        mult_valid_o    = r_mul_valid | w_div_valid;
        result_o        = '0;
        mult_trans_id_o = '0;
        if (r_mul_valid) begin
            result_o        = r_mul_result;
            mult_trans_id_o = r_mul_id;
        end else if (w_div_valid) begin
            result_o        = w_div_result;
            mult_trans_id_o = w_div_id;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult
// Description : Directed and randomized self-checking bench for mult.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult;
    import mult_pkg::*;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned TIDB    = 3;
    localparam int          DIV_LAT = XLEN + 2;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             flush_i = 1'b0;
    logic             mult_valid_i = 1'b0;
    fu_data_t         fu_data_i = '0;
    logic [XLEN-1:0]  result_o;
    logic             mult_valid_o;
    logic             mult_ready_o;
    logic [TIDB-1:0]  mult_trans_id_o;

    int n_cmp  = 0;
    int n_fail = 0;

    fu_op_t ops [13] = '{MUL, MULH, MULHSU, MULHU, MULW, DIV, DIVU, REM, REMU,
                         DIVW, DIVUW, REMW, REMUW};

    always #5 clk = ~clk;

    mult #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .fu_data_i       (fu_data_i),
        .mult_valid_i    (mult_valid_i),
        .result_o        (result_o),
        .mult_valid_o    (mult_valid_o),
        .mult_ready_o    (mult_ready_o),
        .mult_trans_id_o (mult_trans_id_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Plain-arithmetic reference: wide products and the language's own
    // truncating division, with the architectural special cases on top.
    function automatic logic [63:0] ref_model(input fu_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       pa, pb, p;
        logic [63:0]        x, y, q, r, res;
        logic signed [63:0] sx, sy;
        bit                 sgn, w, rm;
        case (op)
            MUL:    return a * b;
            MULH:   begin pa = {{64{a[63]}}, a}; pb = {{64{b[63]}}, b}; p = pa * pb; return p[127:64]; end
            MULHSU: begin pa = {{64{a[63]}}, a}; pb = {64'h0, b};       p = pa * pb; return p[127:64]; end
            MULHU:  begin pa = {64'h0, a};       pb = {64'h0, b};       p = pa * pb; return p[127:64]; end
            MULW:   begin res = a * b; return sext32(res); end
            default: begin
                sgn = op inside {DIV, REM, DIVW, REMW};
                w   = op inside {DIVW, DIVUW, REMW, REMUW};
                rm  = op inside {REM, REMU, REMW, REMUW};
                x = w ? (sgn ? sext32(a) : {32'h0, a[31:0]}) : a;
                y = w ? (sgn ? sext32(b) : {32'h0, b[31:0]}) : b;
                if (y == 64'h0) begin
                    q = '1; r = x;
                end else if (sgn && x == 64'h8000_0000_0000_0000 && y == '1) begin
                    q = x; r = 64'h0;
                end else if (sgn) begin
                    sx = x; sy = y; q = sx / sy; r = sx % sy;
                end else begin
                    q = x / y; r = x % y;
                end
                res = rm ? r : q;
                return w ? sext32(res) : res;
            end
        endcase
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 6))
            0:       return 64'h0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'($urandom_range(0, 20));
            5:       return {32'h0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic drive(input fu_op_t op, input logic [63:0] a, input logic [63:0] b, input logic [TIDB-1:0] id);
        fu_data_i    = '{operator: op, operand_a: a, operand_b: b, trans_id: id};
        mult_valid_i = 1'b1;
    endtask

    task automatic run_op(input string tag, input fu_op_t op, input logic [63:0] a,
                          input logic [63:0] b, input logic [TIDB-1:0] id, input logic [63:0] exp);
        int cyc;
        int bad;
        @(negedge clk);
        check({tag, "_idle_valid"}, 64'(mult_valid_o), 64'd0);
        check({tag, "_idle_ready"}, 64'(mult_ready_o), 64'd1);
        drive(op, a, b, id);
        @(negedge clk);
        mult_valid_i = 1'b0;
        cyc = 1;
        bad = 0;
        if (is_div_op(op)) begin
            while (!mult_valid_o && cyc < DIV_LAT + 20) begin
                if (mult_ready_o) bad++;
                @(negedge clk);
                cyc++;
            end
            check({tag, "_latency"}, 64'(cyc), 64'(DIV_LAT));
            check({tag, "_busy_ready"}, 64'(bad), 64'd0);
            check({tag, "_done_ready"}, 64'(mult_ready_o), 64'd1);
        end
        check({tag, "_valid"}, 64'(mult_valid_o), 64'd1);
        check({tag, "_result"}, result_o, exp);
        check({tag, "_id"}, 64'(mult_trans_id_o), 64'(id));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]     ba [4];
        logic [63:0]     bb [4];
        logic [63:0]     a, b;
        logic [TIDB-1:0] rid;
        fu_op_t          op;
        int              seen;

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(mult_valid_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_id", 64'(mult_trans_id_o), 64'd0);
        check("rst_ready", 64'(mult_ready_o), 64'd1);
        rst_ni = 1'b1;

        run_op("mul_ref", MUL, 64'h1234_5678, 64'h1234_5678, 3'd1, 64'h014B_66DC_1DF4_D840);
        run_op("div_ref", DIV, 64'h1234_5678, 64'h1234_5678, 3'd2, 64'd1);
        run_op("div_by0", DIV, 64'd7, 64'd0, 3'd3, '1);
        run_op("rem_by0", REM, 64'd7, 64'd0, 3'd4, 64'd7);
        run_op("div_ovf", DIV, 64'h8000_0000_0000_0000, '1, 3'd5, 64'h8000_0000_0000_0000);
        run_op("rem_ovf", REM, 64'h8000_0000_0000_0000, '1, 3'd6, 64'd0);
        run_op("mulh_m1", MULH, '1, '1, 3'd7, 64'd0);
        run_op("mulhu_max", MULHU, '1, '1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("div_neg", DIV, -64'sd7, 64'd2, 3'd1, -64'sd3);
        run_op("rem_neg", REM, -64'sd7, 64'd2, 3'd2, -64'sd1);
        run_op("mulhsu_neg", MULHSU, '1, 64'd2, 3'd3, '1);
        run_op("mulw_wrap", MULW, 64'h7FFF_FFFF, 64'd2, 3'd4, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("divw_ovf", DIVW, 64'h0000_0000_8000_0000, '1, 3'd5, 64'hFFFF_FFFF_8000_0000);
        run_op("remuw_by0", REMUW, 64'hABCD_0000_8000_0007, 64'hFFFF_0000_0000_0000, 3'd6,
               64'hFFFF_FFFF_8000_0007);

        // Flush in the middle of a divide
        @(negedge clk);
        drive(DIVU, 64'd1000, 64'd7, 3'd5);
        @(negedge clk);
        mult_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        check("flush_busy", 64'(mult_ready_o), 64'd0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_ready", 64'(mult_ready_o), 64'd1);
        seen = 0;
        repeat (DIV_LAT + 10) begin
            if (mult_valid_o) seen++;
            @(negedge clk);
        end
        check("flush_no_result", 64'(seen), 64'd0);
        run_op("post_flush_mul", MUL, 64'd6, 64'd7, 3'd6, 64'd42);

        // A request coinciding with flush is dropped
        @(negedge clk);
        drive(MUL, 64'd3, 64'd3, 3'd7);
        flush_i = 1'b1;
        @(negedge clk);
        mult_valid_i = 1'b0;
        flush_i = 1'b0;
        check("flush_drop_valid", 64'(mult_valid_o), 64'd0);

        // Back-to-back multiplies
        for (int i = 0; i < 4; i++) begin
            ba[i] = {$urandom, $urandom};
            bb[i] = {$urandom, $urandom};
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("b2b_valid", 64'(mult_valid_o), 64'd1);
                check("b2b_id", 64'(mult_trans_id_o), 64'(i - 1));
                check("b2b_result", result_o, ref_model(MUL, ba[i-1], bb[i-1]));
            end
            if (i < 4) begin
                check("b2b_ready", 64'(mult_ready_o), 64'd1);
                drive(MUL, ba[i], bb[i], TIDB'(i));
            end else begin
                mult_valid_i = 1'b0;
            end
        end

        // Reset in the middle of a divide
        @(negedge clk);
        drive(DIV, 64'd99, 64'd9, 3'd2);
        @(negedge clk);
        mult_valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", 64'(mult_valid_o), 64'd0);
        check("mid_rst_result", result_o, 64'd0);
        check("mid_rst_ready", 64'(mult_ready_o), 64'd1);
        @(negedge clk);
        rst_ni = 1'b1;
        seen = 0;
        repeat (DIV_LAT + 10) begin
            if (mult_valid_o) seen++;
            @(negedge clk);
        end
        check("mid_rst_no_result", 64'(seen), 64'd0);

        for (int n = 0; n < 40; n++) begin
            op  = ops[$urandom_range(0, 12)];
            a   = pick();
            b   = pick();
            rid = TIDB'($urandom_range(0, 7));
            run_op($sformatf("rnd%0d_%s", n, op.name()), op, a, b, rid, ref_model(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
